// File: rtl/lcd_controller.sv
// HD44780-compatible 8-bit character LCD driver.
// Runs the power-up wait and the four-command init sequence after reset.
// It then times out one {rs, rw, data} word per accepted lcd_enable strobe.
module lcd_controller #(
    parameter int unsigned CLK_PER_US   = 50,
    parameter int unsigned T_POWERUP_US = 50000,
    parameter int unsigned T_CMD_US     = 50,
    parameter int unsigned T_CLEAR_US   = 2000,
    parameter bit          BACKLIGHT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_enable,
    input  logic [9:0] lcd_bus,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       lcd_on,
    output logic       lcd_blon
);

    localparam int unsigned PU_CYC  = T_POWERUP_US * CLK_PER_US;
    localparam int unsigned CMD_CYC = T_CMD_US * CLK_PER_US;
    localparam int unsigned CLR_CYC = T_CLEAR_US * CLK_PER_US;
    localparam int unsigned E_CYC   = 2 * CLK_PER_US + 1;
    localparam int unsigned MAX_A   = (PU_CYC > CLR_CYC) ? PU_CYC : CLR_CYC;
    localparam int unsigned MAX_B   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(PU_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] E_ON     = CNT_W'(CLK_PER_US);
    localparam logic [CNT_W-1:0] E_OFF    = CNT_W'(2 * CLK_PER_US);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_POWER_UP,
        ST_INIT,
        ST_READY,
        ST_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;

    // The rw bit of the request word is accepted but never used: the panel is write-only.
    logic unused_rw;
    assign unused_rw = lcd_bus[8];

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;  // function set: 8-bit, 2 lines, 5x8
            2'd1:    init_cmd = 8'h0C;  // display on, cursor off
            2'd2:    init_cmd = 8'h01;  // clear display
            default: init_cmd = 8'h06;  // entry mode: increment, no shift
        endcase
    endfunction

    // Clear and return-home need the long execution time; everything else is short.
    function automatic logic [CNT_W-1:0] write_last(input logic rs, input logic [7:0] data);
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) begin
            write_last = CLR_LAST;
        end else begin
            write_last = CMD_LAST;
        end
    endfunction

    // Next-state, counter and output computation for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            ST_POWER_UP: begin
                if (cnt_q == PU_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_INIT: begin
                if (cnt_q == write_last(rs_q, data_q)) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = ST_READY;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        rs_d   = 1'b0;
                        data_d = init_cmd(idx_q + 2'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_READY: begin
                if (lcd_enable) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                    rs_d    = lcd_bus[9];
                    data_d  = lcd_bus[7:0];
                end
            end
            ST_SEND: begin
                if (cnt_q == write_last(rs_q, data_q)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_POWER_UP;
                cnt_d   = '0;
                idx_d   = 2'd0;
            end
        endcase
        // Outputs are registered, so they are derived from the next state and count.
        busy_d = (state_d != ST_READY);
        e_d    = ((state_d == ST_INIT) || (state_d == ST_SEND)) &&
                 (cnt_d >= E_ON) && (cnt_d < E_OFF);
    end

    // State and registered outputs; reset restarts the whole power-up sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_POWER_UP;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = data_q;
    assign lcd_on   = 1'b1;
    assign lcd_blon = BACKLIGHT;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with reduced timing parameters.
module tb_lcd_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_enable;
    logic [9:0] lcd_bus;
    logic       busy;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       lcd_on;
    logic       lcd_blon;

    lcd_controller #(
        .CLK_PER_US  (4),
        .T_POWERUP_US(20),
        .T_CMD_US    (5),
        .T_CLEAR_US  (10),
        .BACKLIGHT   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lcd_enable(lcd_enable),
        .lcd_bus   (lcd_bus),
        .busy      (busy),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .lcd_on    (lcd_on),
        .lcd_blon  (lcd_blon)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Statistics gathered by watch_write.
    int m_busy_k0, m_busy_len, m_busy_after, m_pulses, m_e_first, m_e_second, m_e_high, m_word_bad;

    typedef struct {
        logic [9:0] bus;
        int         exp_len;
        logic       exp_rs;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at the falling edge where rst has just been released (cycle 0).
    task automatic init_check(input string tag);
        int exp_k[4] = '{84, 104, 124, 164};
        int exp_d[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        int pk[4]    = '{-1, -1, -1, -1};
        int pd[4]    = '{-1, -1, -1, -1};
        int e_early = 0, e_total = 0, pulses = 0, busy_fall = -1, rs_bad = 0, rw_bad = 0;
        logic prev_e = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (lcd_e && c < 80) e_early++;
            if (lcd_e) e_total++;
            if (lcd_e && !prev_e) begin
                if (pulses < 4) begin
                    pk[pulses] = c;
                    pd[pulses] = int'(lcd_data);
                end
                pulses++;
                if (lcd_rs) rs_bad++;
            end
            if (lcd_rw) rw_bad++;
            if (!busy && busy_fall < 0) busy_fall = c;
            prev_e = lcd_e;
            @(negedge clk);
        end
        check({tag, "_e_during_powerup"}, e_early, 0);
        check({tag, "_pulse_count"}, pulses, 4);
        check({tag, "_e_high_cycles"}, e_total, 16);
        check({tag, "_busy_fall_cycle"}, busy_fall, 180);
        check({tag, "_rs_during_init"}, rs_bad, 0);
        check({tag, "_rw_during_init"}, rw_bad, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_cmd%0d_e_start", tag, i), pk[i], exp_k[i]);
            check($sformatf("%s_cmd%0d_data", tag, i), pd[i], exp_d[i]);
        end
        check({tag, "_busy_after_init"}, int'(busy), 0);
    endtask

    // Issue one write from READY and watch ncyc cycles counted from the accepting edge.
    // lcd_enable stays high through cycle en_until (-1: single-cycle strobe); at cycle
    // inj_k a one-cycle strobe carrying inj_bus is driven while the write is in flight.
    task automatic watch_write(input string tag, input logic [9:0] bus, input logic exp_rs,
                               input logic [7:0] exp_data, input int ncyc, input int en_until,
                               input int inj_k, input logic [9:0] inj_bus);
        int   w = 0;
        logic prev_e = 1'b0;
        while (busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready_before_write"}, int'(busy), 0);
        lcd_bus    = bus;
        lcd_enable = 1'b1;
        @(negedge clk);
        m_busy_k0 = -1; m_busy_len = -1; m_busy_after = 0; m_pulses = 0;
        m_e_first = -1; m_e_second = -1; m_e_high = 0; m_word_bad = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == 0) m_busy_k0 = int'(busy);
            if (!busy && m_busy_len < 0) m_busy_len = k;
            else if (busy && m_busy_len >= 0) m_busy_after++;
            if (lcd_e) m_e_high++;
            if (lcd_e && !prev_e) begin
                if (m_pulses == 0) m_e_first = k;
                else if (m_pulses == 1) m_e_second = k;
                m_pulses++;
            end
            if (lcd_rs !== exp_rs || lcd_data !== exp_data || lcd_rw !== 1'b0) m_word_bad++;
            prev_e = lcd_e;
            lcd_enable = (k <= en_until) || (k == inj_k);
            if (k == inj_k)     lcd_bus = inj_bus;
            else if (lcd_enable) lcd_bus = bus;
            else                 lcd_bus = ~bus;
            @(negedge clk);
        end
        lcd_enable = 1'b0;
    endtask

    initial begin
        vecs[0] = '{10'b10_0100_0110, 20, 1'b1, 8'h46};  // 'F'
        vecs[1] = '{10'b00_0000_0001, 40, 1'b0, 8'h01};  // clear
        vecs[2] = '{10'b00_1000_0000, 20, 1'b0, 8'h80};  // set DDRAM address
        vecs[3] = '{10'b00_0000_0010, 40, 1'b0, 8'h02};  // return home
        vecs[4] = '{10'b00_0000_0011, 40, 1'b0, 8'h03};  // return home (alias)
        vecs[5] = '{10'b00_0000_0100, 20, 1'b0, 8'h04};  // entry mode, short
        vecs[6] = '{10'b10_0000_0001, 20, 1'b1, 8'h01};  // data 0x01 is short
        vecs[7] = '{10'b11_0100_0001, 20, 1'b1, 8'h41};  // rw bit set, still a write

        rst        = 1'b1;
        lcd_enable = 1'b0;
        lcd_bus    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 1);
        check("rst_lcd_e", int'(lcd_e), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_rw", int'(lcd_rw), 0);
        check("rst_lcd_data", int'(lcd_data), 0);
        check("rst_lcd_on", int'(lcd_on), 1);
        check("rst_lcd_blon", int'(lcd_blon), 1);

        rst = 1'b0;
        init_check("init");

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            watch_write(t, vecs[i].bus, vecs[i].exp_rs, vecs[i].exp_data, 45, -1, -1, 10'h000);
            check({t, "_busy_on_accept"}, m_busy_k0, 1);
            check({t, "_busy_len"}, m_busy_len, vecs[i].exp_len);
            check({t, "_busy_after"}, m_busy_after, 0);
            check({t, "_pulses"}, m_pulses, 1);
            check({t, "_e_start"}, m_e_first, 4);
            check({t, "_e_len"}, m_e_high, 4);
            check({t, "_word_bad_cycles"}, m_word_bad, 0);
        end

        // Strobe during an 'A' write must be dropped, not queued.
        watch_write("ignored", 10'b10_0100_0001, 1'b1, 8'h41, 40, -1, 10, 10'b10_0101_1010);
        check("ignored_busy_len", m_busy_len, 20);
        check("ignored_busy_after", m_busy_after, 0);
        check("ignored_pulses", m_pulses, 1);
        check("ignored_word_bad_cycles", m_word_bad, 0);

        // Held strobe: re-accepted on the single READY cycle after the first write,
        // so the second write starts 20 SEND cycles + 1 READY cycle after the first.
        watch_write("b2b", 10'b10_0100_0011, 1'b1, 8'h43, 45, 20, -1, 10'h000);
        check("b2b_busy_len", m_busy_len, 20);
        check("b2b_second_busy", m_busy_after, 20);
        check("b2b_pulses", m_pulses, 2);
        check("b2b_e_first", m_e_first, 4);
        check("b2b_e_second", m_e_second, 25);
        check("b2b_e_high", m_e_high, 8);
        check("b2b_word_bad_cycles", m_word_bad, 0);

        // Reset in the middle of an lcd_e pulse.
        check("midrst_ready", int'(busy), 0);
        lcd_bus    = 10'b10_0100_0010;
        lcd_enable = 1'b1;
        @(negedge clk);
        lcd_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_e_before", int'(lcd_e), 1);
        check("midrst_data_before", int'(lcd_data), 8'h42);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_e", int'(lcd_e), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_data", int'(lcd_data), 0);
        check("midrst_rs", int'(lcd_rs), 0);
        rst = 1'b0;
        init_check("reinit");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
